// File: rtl/sync_down_timer_pkg.sv
// Shared constants for sync_down_timer: state encoding and default count width.
package sync_down_timer_pkg;

  localparam int STATE_W       = 2;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_down_timer.sv
// Loadable down-counter/timer with a registered terminal-count pulse.
// Build option: define SYNC_DOWN_TIMER_AUTO_RELOAD_EN for periodic reload instead of one-shot.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no run pending; count holds its last value, loads accepted
// RUN     | counting down on enabled edges; loads refused
// DONE    | one-shot reached zero; loads accepted
module sync_down_timer
  import sync_down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             stop,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic             tc_q, tc_nxt;
  logic             load_acc;

`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_nxt;
`endif

  assign load_acc = load_valid & load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= CNT_ZERO;
      tc_q    <= 1'b0;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= CNT_ZERO;
`endif
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
      tc_q    <= tc_nxt;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    count_nxt = count_q;
    tc_nxt    = 1'b0;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
    reload_nxt = reload_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (load_acc) begin
          count_nxt = load_value;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
          reload_nxt = load_value;
`endif
          if (load_value != CNT_ZERO) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_DONE;
            tc_nxt    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // stop outranks en; RUN always holds count >= 1, so no underflow path
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (en) begin
          if (count_q > CNT_ONE) begin
            count_nxt = count_q - CNT_ONE;
          end else begin
            tc_nxt = 1'b1;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
            count_nxt = reload_q;
`else
            count_nxt = CNT_ZERO;
            state_nxt = ST_DONE;
`endif
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    load_ready = (state_q != ST_RUN) & ~stop;
    count      = count_q;
    tc         = tc_q;
  end

endmodule
